axil_cmd_mgr: RTL and testbench
===============================

AXIL_CMD_MGR -- requirements
Module: axil_cmd_mgr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, AXI-Lite address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, maximum wait cycles per AXI phase (2..65535).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk100 in 1, rising-edge clock.
REQ-004 rstn in 1, asynchronous active-low reset.
REQ-005 cmd_valid in 1, command offered.
REQ-006 cmd_ready out 1, command accepted when cmd_valid&cmd_ready.
REQ-007 cmd_wr in 1, 1=write, 0=read.
REQ-008 cmd_addr in ADDR_WIDTH, byte address.
REQ-009 cmd_wdata in 32, write data.
REQ-010 cmd_wstrb in 4, write strobes.
REQ-011 rsp_valid out 1, response available.
REQ-012 rsp_ready in 1, response consumed when rsp_valid&rsp_ready.
REQ-013 rsp_rdata out 32, read data (0 for writes).
REQ-014 rsp_resp out 2, BRESP/RRESP, or 2'b10 on timeout.
REQ-015 rsp_timeout out 1, phase timed out.
REQ-016 busy out 1, high in any state except IDLE.
REQ-017 m_axil_awaddr out ADDR_WIDTH, m_axil_awprot out 3 (fixed 3'b000), m_axil_awvalid out 1, m_axil_awready in 1.
REQ-018 m_axil_wdata out 32, m_axil_wstrb out 4, m_axil_wvalid out 1, m_axil_wready in 1.
REQ-019 m_axil_bresp in 2, m_axil_bvalid in 1, m_axil_bready out 1.
REQ-020 m_axil_araddr out ADDR_WIDTH, m_axil_arprot out 3 (fixed 3'b000), m_axil_arvalid out 1, m_axil_arready in 1.
REQ-021 m_axil_rdata in 32, m_axil_rresp in 2, m_axil_rvalid in 1, m_axil_rready out 1.

Function
REQ-022 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-023 cmd_ready SHALL be 1 only in IDLE; on accept, register addr/wdata/wstrb and go to WR_REQ (cmd_wr=1) or RD_REQ (cmd_wr=0); valids assert on the next cycle.
REQ-024 WR_REQ: awvalid and wvalid assert together; each drops independently on its own handshake; both handshakes, in either order or in the same cycle, move to WR_RESP.
REQ-025 WR_RESP: bready=1; on bvalid, capture bresp, rdata=0, go to RSP.
REQ-026 RD_REQ: arvalid=1 until arready, then RD_DATA.
REQ-027 RD_DATA: rready=1; on rvalid, capture rdata/rresp, go to RSP.
REQ-028 AXI outputs SHALL be registered; address, data and strobe SHALL stay stable while the corresponding valid is high.
REQ-029 RSP: rsp_valid=1 with fields held stable until rsp_ready; then IDLE; new command acceptable the cycle after.
REQ-030 Minimum latency with all AXI readies/valids high: accept at cycle 0, request handshake at 1, response handshake at 2, rsp_valid at 3.
REQ-031 16-bit phase counter SHALL clear on every state entry and increment each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-032 If the counter reaches TIMEOUT_CYC-1 without the phase completing: deassert all AXI valid/ready, set rsp_resp=2'b10, rsp_timeout=1, rdata=0, go to RSP.
REQ-033 A handshake completing in the timeout cycle SHALL take priority (normal response, rsp_timeout=0).
REQ-034 Responses SHALL NOT be counted in RSP (no timeout while waiting for rsp_ready).
REQ-035 SLVERR/DECERR from the slave SHALL pass through unchanged with rsp_timeout=0.

Reset
REQ-036 rstn low SHALL asynchronously force IDLE, clear the counter and drive every output to 0 (cmd_ready=0 while rstn low; 1 from the first clock edge after release), aborting any transaction in flight.

Verification
REQ-037 Write 0x0C, data 0xDEADBEEF, strb 0xF, slave always ready, bresp=0 -> awaddr=0x0C, wdata=0xDEADBEEF on cycle 1, rsp_valid on cycle 3, rsp_resp=0, rsp_timeout=0.
REQ-038 Read 0x04, slave returns 0x12345678 after 5-cycle rvalid delay -> rsp_rdata=0x12345678, rsp_resp=0, arvalid held until arready.
REQ-039 Write with wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds, a single bready handshake follows, one response.
REQ-040 Read with arready never asserted, TIMEOUT_CYC=16 -> arvalid drops after 16 cycles in RD_REQ, rsp_resp=2'b10, rsp_timeout=1, then IDLE.
REQ-041 rsp_ready held low 10 cycles -> rsp fields stable, cmd_ready=0 throughout; rstn pulsed low mid-WR_RESP -> all outputs 0 immediately, IDLE after release.
REQ-042 Slave returns rresp=2'b11 -> rsp_resp=2'b11, rsp_timeout=0.

Source files
------------

// File: rtl/axil_cmd_mgr_if.sv
// AXI-Lite manager-side bus bundle for axil_cmd_mgr.
// The master modport is the command manager; the slave modport is the peripheral side.
interface axil_cmd_mgr_if #(
  parameter int unsigned ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] m_axil_awaddr;
  logic [2:0]            m_axil_awprot;
  logic                  m_axil_awvalid;
  logic                  m_axil_awready;
  logic [31:0]           m_axil_wdata;
  logic [3:0]            m_axil_wstrb;
  logic                  m_axil_wvalid;
  logic                  m_axil_wready;
  logic [1:0]            m_axil_bresp;
  logic                  m_axil_bvalid;
  logic                  m_axil_bready;
  logic [ADDR_WIDTH-1:0] m_axil_araddr;
  logic [2:0]            m_axil_arprot;
  logic                  m_axil_arvalid;
  logic                  m_axil_arready;
  logic [31:0]           m_axil_rdata;
  logic [1:0]            m_axil_rresp;
  logic                  m_axil_rvalid;
  logic                  m_axil_rready;

  modport master (
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid, input m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid, input m_axil_wready,
    input m_axil_bresp, m_axil_bvalid, output m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid, input m_axil_arready,
    input m_axil_rdata, m_axil_rresp, m_axil_rvalid, output m_axil_rready
  );

  modport slave (
    input m_axil_awaddr, m_axil_awprot, m_axil_awvalid, output m_axil_awready,
    input m_axil_wdata, m_axil_wstrb, m_axil_wvalid, output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid, input m_axil_bready,
    input m_axil_araddr, m_axil_arprot, m_axil_arvalid, output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid, input m_axil_rready
  );
endinterface

// File: rtl/axil_cmd_mgr.sv
// Single-outstanding command-to-AXI-Lite manager with per-phase timeout.
// All AXI and response outputs come straight from flops.
module axil_cmd_mgr #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk100,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  axil_cmd_mgr_if.master        m_axil
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  phase_to;
  logic                  aw_left, w_left;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    phase_to      = (cnt_q == TO_LAST);
    aw_left       = awvalid_q && !m_axil.m_axil_awready;
    w_left        = wvalid_q && !m_axil.m_axil_wready;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end else if (phase_to) begin
          state_d = RSP;
        end
      end
      WR_RESP: begin
        if (m_axil.m_axil_bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axil.m_axil_bresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (phase_to) begin
          state_d = RSP;
        end
      end
      RD_REQ: begin
        if (m_axil.m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else if (phase_to) begin
          state_d = RSP;
        end
      end
      RD_DATA: begin
        if (m_axil.m_axil_rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_axil.m_axil_rdata;
          rsp_resp_d    = m_axil.m_axil_rresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (phase_to) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A phase that jumps to RSP without a response captured above timed out.
    if (state_d == RSP && !rsp_valid_d) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA})
      cnt_d = cnt_q + 16'd1;
    else
      cnt_d = cnt_q;

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign m_axil.m_axil_awaddr  = addr_q;
  assign m_axil.m_axil_awprot  = '0;
  assign m_axil.m_axil_awvalid = awvalid_q;
  assign m_axil.m_axil_wdata   = wdata_q;
  assign m_axil.m_axil_wstrb   = wstrb_q;
  assign m_axil.m_axil_wvalid  = wvalid_q;
  assign m_axil.m_axil_bready  = bready_q;
  assign m_axil.m_axil_araddr  = addr_q;
  assign m_axil.m_axil_arprot  = '0;
  assign m_axil.m_axil_arvalid = arvalid_q;
  assign m_axil.m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_mgr.sv
// Directed bench for axil_cmd_mgr: the bench plays the AXI-Lite slave by hand,
// with expected values worked out per step.
module tb_axil_cmd_mgr;

  logic        clk100 = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int n_cmp = 0;
  int n_err = 0;

  axil_cmd_mgr_if #(.ADDR_WIDTH(7)) axil ();

  axil_cmd_mgr #(.ADDR_WIDTH(7), .TIMEOUT_CYC(16)) dut (
    .clk100      (clk100),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .m_axil      (axil.master)
  );

  always #5 clk100 = ~clk100;

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("consume_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("consume_busy", {31'd0, busy}, 32'd0);
    chk("consume_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    axil.m_axil_awready = 1'b0; axil.m_axil_wready = 1'b0;
    axil.m_axil_bvalid = 1'b0; axil.m_axil_bresp = 2'b00;
    axil.m_axil_arready = 1'b0; axil.m_axil_rvalid = 1'b0;
    axil.m_axil_rdata = '0; axil.m_axil_rresp = 2'b00;

    // reset state
    tick(); tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_awvalid", {31'd0, axil.m_axil_awvalid}, 32'd0);
    chk("rst_arvalid", {31'd0, axil.m_axil_arvalid}, 32'd0);
    rstn = 1'b1;
    tick();
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // minimum-latency write
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 7'h0C;
    cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    axil.m_axil_awready = 1'b1; axil.m_axil_wready = 1'b1;
    axil.m_axil_bvalid = 1'b1; axil.m_axil_bresp = 2'b00;
    tick();
    cmd_valid = 1'b0;
    chk("w1_awvalid", {31'd0, axil.m_axil_awvalid}, 32'd1);
    chk("w1_wvalid", {31'd0, axil.m_axil_wvalid}, 32'd1);
    chk("w1_awaddr", {25'd0, axil.m_axil_awaddr}, 32'h0C);
    chk("w1_wdata", axil.m_axil_wdata, 32'hDEADBEEF);
    chk("w1_wstrb", {28'd0, axil.m_axil_wstrb}, 32'hF);
    chk("w1_awprot", {29'd0, axil.m_axil_awprot}, 32'd0);
    chk("w1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("w1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("w2_awvalid", {31'd0, axil.m_axil_awvalid}, 32'd0);
    chk("w2_wvalid", {31'd0, axil.m_axil_wvalid}, 32'd0);
    chk("w2_bready", {31'd0, axil.m_axil_bready}, 32'd1);
    chk("w2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("w3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("w3_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("w3_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("w3_rsp_rdata", rsp_rdata, 32'd0);
    chk("w3_bready", {31'd0, axil.m_axil_bready}, 32'd0);
    axil.m_axil_bvalid = 1'b0;
    axil.m_axil_awready = 1'b0; axil.m_axil_wready = 1'b0;
    consume();

    // read with arready late and a 5-cycle rvalid delay
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 7'h04;
    tick();
    cmd_valid = 1'b0;
    chk("r1_arvalid", {31'd0, axil.m_axil_arvalid}, 32'd1);
    chk("r1_araddr", {25'd0, axil.m_axil_araddr}, 32'h04);
    chk("r1_arprot", {29'd0, axil.m_axil_arprot}, 32'd0);
    chk("r1_awvalid", {31'd0, axil.m_axil_awvalid}, 32'd0);
    tick();
    chk("r2_arvalid_held", {31'd0, axil.m_axil_arvalid}, 32'd1);
    axil.m_axil_arready = 1'b1;
    tick();
    axil.m_axil_arready = 1'b0;
    chk("r3_arvalid", {31'd0, axil.m_axil_arvalid}, 32'd0);
    chk("r3_rready", {31'd0, axil.m_axil_rready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("r_wait_rready", {31'd0, axil.m_axil_rready}, 32'd1);
      chk("r_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    axil.m_axil_rvalid = 1'b1; axil.m_axil_rdata = 32'h12345678; axil.m_axil_rresp = 2'b00;
    tick();
    axil.m_axil_rvalid = 1'b0;
    chk("r4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("r4_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("r4_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("r4_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("r4_rready", {31'd0, axil.m_axil_rready}, 32'd0);
    consume();

    // write with wready three cycles ahead of awready
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 7'h20;
    cmd_wdata = 32'h0000A55A; cmd_wstrb = 4'h3;
    axil.m_axil_wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("s1_awvalid", {31'd0, axil.m_axil_awvalid}, 32'd1);
    chk("s1_wvalid", {31'd0, axil.m_axil_wvalid}, 32'd1);
    tick();
    axil.m_axil_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s_wvalid_dropped", {31'd0, axil.m_axil_wvalid}, 32'd0);
      chk("s_awvalid_held", {31'd0, axil.m_axil_awvalid}, 32'd1);
      chk("s_awaddr_stable", {25'd0, axil.m_axil_awaddr}, 32'h20);
      chk("s_bready_low", {31'd0, axil.m_axil_bready}, 32'd0);
      if (i == 2) axil.m_axil_awready = 1'b1;
      tick();
    end
    axil.m_axil_awready = 1'b0;
    chk("s2_awvalid", {31'd0, axil.m_axil_awvalid}, 32'd0);
    chk("s2_bready", {31'd0, axil.m_axil_bready}, 32'd1);
    axil.m_axil_bvalid = 1'b1; axil.m_axil_bresp = 2'b00;
    tick();
    axil.m_axil_bvalid = 1'b0;
    chk("s3_bready_once", {31'd0, axil.m_axil_bready}, 32'd0);
    chk("s3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("s3_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    consume();
    chk("s4_no_second_rsp", {31'd0, rsp_valid}, 32'd0);

    // read timeout: arready never asserted
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 7'h44;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t_arvalid_held", {31'd0, axil.m_axil_arvalid}, 32'd1);
      tick();
    end
    chk("t_arvalid_drop", {31'd0, axil.m_axil_arvalid}, 32'd0);
    chk("t_rready", {31'd0, axil.m_axil_rready}, 32'd0);
    chk("t_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t_rsp_resp", {30'd0, rsp_resp}, 32'd2);
    chk("t_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    chk("t_rsp_rdata", rsp_rdata, 32'd0);
    consume();

    // arready in the timeout cycle wins over the timeout
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 7'h48;
    tick();
    cmd_valid = 1'b0;
    repeat (15) tick();
    chk("p_arvalid_last", {31'd0, axil.m_axil_arvalid}, 32'd1);
    axil.m_axil_arready = 1'b1;
    tick();
    axil.m_axil_arready = 1'b0;
    chk("p_rready", {31'd0, axil.m_axil_rready}, 32'd1);
    chk("p_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    axil.m_axil_rvalid = 1'b1; axil.m_axil_rdata = 32'h0BADF00D; axil.m_axil_rresp = 2'b00;
    tick();
    axil.m_axil_rvalid = 1'b0;
    chk("p_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("p_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("p_rsp_rdata", rsp_rdata, 32'h0BADF00D);
    consume();

    // SLVERR write, response held off for 10 cycles with a pending command
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 7'h10;
    cmd_wdata = 32'h11112222; cmd_wstrb = 4'hC;
    axil.m_axil_awready = 1'b1; axil.m_axil_wready = 1'b1;
    axil.m_axil_bvalid = 1'b1; axil.m_axil_bresp = 2'b10;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    axil.m_axil_bvalid = 1'b0;
    axil.m_axil_awready = 1'b0; axil.m_axil_wready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("h_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("h_rsp_resp", {30'd0, rsp_resp}, 32'd2);
      chk("h_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
      chk("h_rsp_rdata", rsp_rdata, 32'd0);
      chk("h_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    consume();

    // DECERR read passes through
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 7'h7C;
    axil.m_axil_arready = 1'b1;
    axil.m_axil_rvalid = 1'b1; axil.m_axil_rdata = 32'hCAFE0001; axil.m_axil_rresp = 2'b11;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    axil.m_axil_arready = 1'b0; axil.m_axil_rvalid = 1'b0;
    chk("d_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("d_rsp_resp", {30'd0, rsp_resp}, 32'd3);
    chk("d_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("d_rsp_rdata", rsp_rdata, 32'hCAFE0001);
    consume();

    // reset pulsed in the middle of WR_RESP
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 7'h30;
    cmd_wdata = 32'h87654321; cmd_wstrb = 4'hF;
    axil.m_axil_awready = 1'b1; axil.m_axil_wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    axil.m_axil_awready = 1'b0; axil.m_axil_wready = 1'b0;
    chk("x_bready_before", {31'd0, axil.m_axil_bready}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("x_bready", {31'd0, axil.m_axil_bready}, 32'd0);
    chk("x_busy", {31'd0, busy}, 32'd0);
    chk("x_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("x_awaddr", {25'd0, axil.m_axil_awaddr}, 32'd0);
    chk("x_wdata", axil.m_axil_wdata, 32'd0);
    chk("x_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    rstn = 1'b1;
    chk("x_cmd_ready_rel", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("x_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("x_idle_busy", {31'd0, busy}, 32'd0);
    chk("x_idle_bready", {31'd0, axil.m_axil_bready}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
